// File: rtl/systolic_mtrxa_skew_feeder.sv
// systolic_mtrxa_skew_feeder
//   Buffers one A-matrix tile that arrives one element per beat in column-major
//   order (k outer, row inner). When the array signals arr_start, the tile is
//   replayed into the per-row inputs with a diagonal skew: row r runs r cycles
//   behind row 0.
//
// Ports
//   s_clk, s_rst_n     clock; asynchronous active-low reset
//   slice_valid/data   incoming tile element
//   slice_done         end of tile; may share a cycle with the last accepted beat
//   slice_ready        element accepted this cycle (registered)
//   arr_start          array is ready for the skewed replay
//   feed_busy          a tile is held or being replayed
//   row_valid/row_data per-row skewed output; row r at [r*DATA_WIDTH +: DATA_WIDTH]
//   feed_done          one-cycle pulse after the last skewed beat
//   pad_err            sticky: the last tile ended mid-column and was zero-padded
//   tile_cnt, pad_cnt  (MTRXA_FEEDER_STATS_EN only) replayed-tile and padded-tile counters
//
// Configuration macro: MTRXA_FEEDER_STATS_EN

// One row lane: column buffer plus a registered skewed read port.
module systolic_mtrxa_row_buf #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 64,
  parameter int LANE       = 0,
  parameter int AW         = 6,
  parameter int KW         = 7,
  parameter int TW         = 8
) (
  input  logic                  s_clk,
  input  logic                  s_rst_n,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  drain,
  input  logic [TW-1:0]         t,
  input  logic [KW-1:0]         ktile,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [TW-1:0]         rel;
  logic                  hit;

  // This lane reads column t-LANE; the t>=LANE test keeps the subtraction
  // from wrapping into a bogus in-range address.
  assign rel = t - TW'(LANE);
  assign hit = drain && (t >= TW'(LANE)) && (rel < TW'(ktile));

  always_ff @(posedge s_clk)
    if (wr_en) mem[wr_addr] <= wr_data;

  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= hit;
      out_data  <= hit ? mem[rel[AW-1:0]] : '0;
    end
  end
endmodule

module systolic_mtrxa_skew_feeder #(
  parameter int UNIT_NUM   = 8,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 64
) (
  input  logic                           s_clk,
  input  logic                           s_rst_n,
  input  logic                           slice_valid,
  input  logic [DATA_WIDTH-1:0]          slice_data,
  input  logic                           slice_done,
  output logic                           slice_ready,
  input  logic                           arr_start,
  output logic                           feed_busy,
  output logic [UNIT_NUM-1:0]            row_valid,
  output logic [UNIT_NUM*DATA_WIDTH-1:0] row_data,
  output logic                           feed_done,
`ifdef MTRXA_FEEDER_STATS_EN
  output logic [31:0]                    tile_cnt,
  output logic [15:0]                    pad_cnt,
`endif
  output logic                           pad_err
);
  localparam int RW = (UNIT_NUM > 1) ? $clog2(UNIT_NUM) : 1;
  localparam int AW = $clog2(DEPTH);
  localparam int KW = AW + 1;
  localparam int TW = $clog2(DEPTH + UNIT_NUM) + 1;

  localparam logic [RW-1:0] R_LAST = RW'(UNIT_NUM - 1);
  localparam logic [KW-1:0] K_FULL = KW'(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_DRAIN, S_DONE} state_t;

  typedef struct packed {
    logic                  en;
    logic [RW-1:0]         row;
    logic [AW-1:0]         addr;
    logic [DATA_WIDTH-1:0] data;
  } wr_req_t;

  state_t        state, state_n;
  logic [RW-1:0] r, r_n, adv_r, pos_r;
  logic [KW-1:0] k, k_n, adv_k, pos_k;
  logic [KW-1:0] ktile, ktile_n;
  logic [TW-1:0] t, t_n;
  logic          pad, pad_n;
  logic          perr_n, ready_n;
  logic          accept, pad_start;
  wr_req_t       wr;

  logic [UNIT_NUM-1:0][DATA_WIDTH-1:0] row_data_a;

  // slice_ready is only ever high in S_LOAD, outside padding, while not full.
  assign accept = slice_valid & slice_ready;

  // Buffer position after this cycle's accept; slice_done is judged on it so a
  // beat arriving with done still belongs to the tile.
  assign adv_r = (r == R_LAST) ? '0 : r + RW'(1);
  assign adv_k = (r == R_LAST) ? k + KW'(1) : k;
  assign pos_r = accept ? adv_r : r;
  assign pos_k = accept ? adv_k : k;

  assign pad_start = (state == S_LOAD) && !pad && slice_done && (pos_r != '0);

  always_comb begin
    state_n = state;
    r_n     = r;
    k_n     = k;
    ktile_n = ktile;
    t_n     = t;
    pad_n   = pad;
    perr_n  = pad_err;
    wr      = '{en: 1'b0, row: r, addr: k[AW-1:0], data: slice_data};
    case (state)
      S_IDLE: begin
        state_n = S_LOAD;
        r_n     = '0;
        k_n     = '0;
        t_n     = '0;
        pad_n   = 1'b0;
      end
      S_LOAD: begin
        if (pad) begin
          // Zero-fill the rest of the ragged last column, one row per cycle.
          wr.en   = 1'b1;
          wr.data = '0;
          r_n     = adv_r;
          k_n     = adv_k;
          if (r == R_LAST) begin
            pad_n   = 1'b0;
            ktile_n = adv_k;
            state_n = S_WAIT;
          end
        end else begin
          if (accept) begin
            wr.en = 1'b1;
            r_n   = adv_r;
            k_n   = adv_k;
            if (r == '0 && k == '0) perr_n = 1'b0;
          end
          if (slice_done) begin
            if (pos_r != '0) begin
              pad_n  = 1'b1;
              perr_n = 1'b1;
            end else begin
              ktile_n = pos_k;
              state_n = (pos_k == '0) ? S_DONE : S_WAIT;
            end
          end
        end
      end
      S_WAIT: begin
        t_n = '0;
        if (arr_start) state_n = S_DRAIN;
      end
      S_DRAIN: begin
        t_n = t + TW'(1);
        if (t == TW'(ktile) + TW'(UNIT_NUM - 1)) state_n = S_DONE;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    ready_n = (state_n == S_LOAD) && !pad_n && (k_n != K_FULL);
  end

  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state       <= S_IDLE;
      r           <= '0;
      k           <= '0;
      ktile       <= '0;
      t           <= '0;
      pad         <= 1'b0;
      pad_err     <= 1'b0;
      slice_ready <= 1'b0;
    end else begin
      state       <= state_n;
      r           <= r_n;
      k           <= k_n;
      ktile       <= ktile_n;
      t           <= t_n;
      pad         <= pad_n;
      pad_err     <= perr_n;
      slice_ready <= ready_n;
    end
  end

  assign feed_done = (state == S_DONE);
  assign feed_busy = (state == S_WAIT) || (state == S_DRAIN) || (state == S_DONE) ||
                     ((state == S_LOAD) && (k != '0 || r != '0 || pad));

  for (genvar g = 0; g < UNIT_NUM; g++) begin : g_row
    systolic_mtrxa_row_buf #(
      .DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .LANE(g),
      .AW(AW), .KW(KW), .TW(TW)
    ) u_row (
      .s_clk    (s_clk),
      .s_rst_n  (s_rst_n),
      .wr_en    (wr.en && (wr.row == RW'(g))),
      .wr_addr  (wr.addr),
      .wr_data  (wr.data),
      .drain    (state == S_DRAIN),
      .t        (t),
      .ktile    (ktile),
      .out_valid(row_valid[g]),
      .out_data (row_data_a[g])
    );
  end

  assign row_data = row_data_a;

`ifdef MTRXA_FEEDER_STATS_EN
  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      tile_cnt <= '0;
      pad_cnt  <= '0;
    end else begin
      if (feed_done) tile_cnt <= tile_cnt + 32'd1;
      if (pad_start && pad_cnt != 16'hFFFF) pad_cnt <= pad_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_systolic_mtrxa_skew_feeder.sv
module tb_systolic_mtrxa_skew_feeder;
  localparam int U  = 4;
  localparam int DW = 16;
  localparam int D  = 16;

  logic          s_clk = 1'b0;
  logic          s_rst_n = 1'b0;
  logic          slice_valid = 1'b0;
  logic [DW-1:0] slice_data = '0;
  logic          slice_done = 1'b0;
  logic          arr_start = 1'b0;
  logic          slice_ready, feed_busy, feed_done, pad_err;
  logic [U-1:0]  row_valid;
  logic [U*DW-1:0] row_data;
`ifdef MTRXA_FEEDER_STATS_EN
  logic [31:0]   tile_cnt;
  logic [15:0]   pad_cnt;
`endif

  systolic_mtrxa_skew_feeder #(.UNIT_NUM(U), .DATA_WIDTH(DW), .DEPTH(D)) dut (
    .s_clk(s_clk), .s_rst_n(s_rst_n),
    .slice_valid(slice_valid), .slice_data(slice_data), .slice_done(slice_done),
    .slice_ready(slice_ready), .arr_start(arr_start), .feed_busy(feed_busy),
    .row_valid(row_valid), .row_data(row_data), .feed_done(feed_done),
`ifdef MTRXA_FEEDER_STATS_EN
    .tile_cnt(tile_cnt), .pad_cnt(pad_cnt),
`endif
    .pad_err(pad_err)
  );

  always #5 s_clk = ~s_clk;

  int cyc = 0;
  always @(posedge s_clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Model: the tile as a matrix A[r][k], the cycle arr_start was raised, and
  // the cycle feed_done must pulse.
  int          base = -1000;
  int          fd_cycle = -1;
  int          mK = 0;
  logic [DW-1:0] mA [U][D];
  logic [DW-1:0] mq [$];
  bit          chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Row r carries column j at cycle base+2+r+j; everything else is zero.
  always @(negedge s_clk) begin
    if (chk_en) begin
      logic [U-1:0]    ev;
      logic [U*DW-1:0] ed;
      ev = '0;
      ed = '0;
      for (int rr = 0; rr < U; rr++) begin
        automatic int j = cyc - (base + 2 + rr);
        if (j >= 0 && j < mK) begin
          ev[rr] = 1'b1;
          ed[rr*DW +: DW] = mA[rr][j];
        end
      end
      chk("row_valid", 64'(row_valid), 64'(ev));
      chk("row_data", 64'(row_data), 64'(ed));
      chk("feed_done", 64'(feed_done), 64'(cyc == fd_cycle));
    end
  end

  task automatic tick();
    @(posedge s_clk);
    #1;
  endtask

  task automatic at_neg(input int n);
    while (cyc < n) tick();
    @(negedge s_clk);
  endtask

  task automatic wait_ready();
    int w;
    w = 0;
    while (!slice_ready && w < 100) begin tick(); w++; end
    chk("ready_wait", 64'(slice_ready), 64'd1);
  endtask

  task automatic push(input logic [DW-1:0] d, input bit done);
    slice_valid = 1'b1;
    slice_data  = d;
    wait_ready();
    slice_done = done;
    mq.push_back(d);
    tick();
    slice_valid = 1'b0;
    slice_done  = 1'b0;
  endtask

  task automatic finish_model();
    int n;
    n  = mq.size();
    mK = (n + U - 1) / U;
    for (int rr = 0; rr < U; rr++)
      for (int kk = 0; kk < D; kk++)
        mA[rr][kk] = (kk * U + rr < n) ? mq[kk*U+rr] : '0;
    mq.delete();
  endtask

  task automatic start_drain(input int delay);
    repeat (delay) tick();
    arr_start = 1'b1;
    base      = cyc;
    fd_cycle  = cyc + mK + U + 1;
    tick();
    arr_start = 1'b0;
  endtask

  task automatic drain_wait();
    while (cyc <= fd_cycle + 1) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int c;
    repeat (2) @(posedge s_clk);
    #1;
    chk("rst_row_valid", 64'(row_valid), 64'd0);
    chk("rst_row_data", 64'(row_data), 64'd0);
    chk("rst_feed_done", 64'(feed_done), 64'd0);
    chk("rst_feed_busy", 64'(feed_busy), 64'd0);
    chk("rst_ready", 64'(slice_ready), 64'd0);
    chk("rst_pad_err", 64'(pad_err), 64'd0);
    s_rst_n = 1'b1;
    chk_en  = 1'b1;

    // Full tile, 12 beats, K=3
    for (int i = 1; i <= 12; i++) push(DW'(i), i == 12);
    finish_model();
    chk("full_busy_wait", 64'(feed_busy), 64'd1);
    chk("full_pad_err", 64'(pad_err), 64'd0);
    start_drain(3);
    c = base;
    at_neg(c + 2);
    chk("full_r0_first", 64'(row_data[15:0]), 64'h1);
    chk("full_vld_c2", 64'(row_valid), 64'b0001);
    at_neg(c + 4);
    chk("full_r0_last", 64'(row_data[15:0]), 64'h9);
    at_neg(c + 5);
    chk("full_vld_c5", 64'(row_valid), 64'b1110);
    chk("full_r3_first", 64'(row_data[63:48]), 64'h4);
    at_neg(c + 7);
    chk("full_r3_last", 64'(row_data[63:48]), 64'hC);
    chk("full_vld_c7", 64'(row_valid), 64'b1000);
    at_neg(c + 8);
    chk("full_feed_done", 64'(feed_done), 64'd1);
    drain_wait();
    chk("full_busy_after", 64'(feed_busy), 64'd0);

    // Partial tile, 10 beats, arr_start during load must be ignored
    for (int i = 0; i < 5; i++) push(DW'(16'h11 + i), 1'b0);
    arr_start = 1'b1;
    tick();
    arr_start = 1'b0;
    for (int i = 5; i < 10; i++) push(DW'(16'h11 + i), 1'b0);
    slice_done = 1'b1;
    tick();
    slice_done = 1'b0;
    finish_model();
    chk("part_pad_err", 64'(pad_err), 64'd1);
    start_drain(5);
    c = base;
    at_neg(c + 6);
    chk("part_vld_c6", 64'(row_valid), 64'b1100);
    chk("part_r2_pad", 64'(row_data[47:32]), 64'h0);
    at_neg(c + 7);
    chk("part_r3_pad", 64'(row_data[63:48]), 64'h0);
    chk("part_vld_c7", 64'(row_valid), 64'b1000);
    drain_wait();

    // Same tile as the first, with gaps and a late arr_start
    chk("bp_pad_err_held", 64'(pad_err), 64'd1);
    push(DW'(1), 1'b0);
    chk("bp_pad_err_clr", 64'(pad_err), 64'd0);
    for (int i = 2; i <= 12; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      push(DW'(i), i == 12);
    end
    finish_model();
    start_drain(8);
    c = base;
    at_neg(c + 2);
    chk("bp_r0_first", 64'(row_data[15:0]), 64'h1);
    at_neg(c + 8);
    chk("bp_feed_done", 64'(feed_done), 64'd1);
    drain_wait();

    // Buffer full: 64 beats, further beat refused until done
    for (int i = 0; i < 64; i++) push(DW'(16'h100 + i), 1'b0);
    slice_valid = 1'b1;
    slice_data  = 16'hDEAD;
    chk("fill_ready_low0", 64'(slice_ready), 64'd0);
    tick();
    chk("fill_ready_low1", 64'(slice_ready), 64'd0);
    chk("fill_busy", 64'(feed_busy), 64'd1);
    slice_done = 1'b1;
    tick();
    slice_done  = 1'b0;
    slice_valid = 1'b0;
    finish_model();
    start_drain(5);
    c = base;
    at_neg(c + 17);
    chk("fill_r0_col15", 64'(row_data[15:0]), 64'h13C);
    drain_wait();

    // Empty tile
    wait_ready();
    slice_done = 1'b1;
    fd_cycle   = cyc + 1;
    tick();
    slice_done = 1'b0;
    @(negedge s_clk);
    chk("empty_feed_done", 64'(feed_done), 64'd1);
    chk("empty_row_valid", 64'(row_valid), 64'd0);
    repeat (3) tick();

    // Reset in the middle of a drain
    for (int i = 1; i <= 12; i++) push(DW'(16'h40 + i), i == 12);
    finish_model();
    start_drain(4);
    c = base;
    while (cyc < c + 3) tick();
    s_rst_n  = 1'b0;
    base     = -1000;
    fd_cycle = -1;
    #1;
    chk("mrst_row_valid", 64'(row_valid), 64'd0);
    chk("mrst_row_data", 64'(row_data), 64'd0);
    chk("mrst_feed_busy", 64'(feed_busy), 64'd0);
    chk("mrst_ready", 64'(slice_ready), 64'd0);
    chk("mrst_feed_done", 64'(feed_done), 64'd0);
    tick();
    tick();
    s_rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) push(DW'(16'h70 + i), i == 8);
    finish_model();
    start_drain(4);
    c = base;
    at_neg(c + 3);
    chk("post_r1_first", 64'(row_data[31:16]), 64'h72);
    drain_wait();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
